// File: rtl/register_bank_sb.sv
// register_bank_sb: 32x WIDTH architectural register bank with a pending-write scoreboard for RAW hazard detection
module register_bank_sb #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [WIDTH-1:0] Q8,
    output logic [WIDTH-1:0] Q9,
    output logic [WIDTH-1:0] Q10,
    output logic [WIDTH-1:0] Q11,
    output logic [WIDTH-1:0] Q12,
    output logic [WIDTH-1:0] Q13,
    output logic [WIDTH-1:0] Q14,
    output logic [WIDTH-1:0] Q15,
    output logic [WIDTH-1:0] Q16,
    output logic [WIDTH-1:0] Q17,
    output logic [WIDTH-1:0] Q18,
    output logic [WIDTH-1:0] Q19,
    output logic [WIDTH-1:0] Q20,
    output logic [WIDTH-1:0] Q21,
    output logic [WIDTH-1:0] Q22,
    output logic [WIDTH-1:0] Q23,
    output logic [WIDTH-1:0] Q24,
    output logic [WIDTH-1:0] Q25,
    output logic [WIDTH-1:0] Q26,
    output logic [WIDTH-1:0] Q27,
    output logic [WIDTH-1:0] Q28,
    output logic [WIDTH-1:0] Q29,
    output logic [WIDTH-1:0] Q30,
    output logic [WIDTH-1:0] Q31,
    output logic [31:0]      pending
);
    logic [WIDTH-1:0] regs [32];
    logic [31:0]      pend_nxt;
    logic             wr_en;

    assign wr_en = we && !(ZERO_R0 && wa == 5'd0);

    // Set beats clear on the same address; flush overrides both; R0 can never be pending when hardwired
    always_comb begin
        pend_nxt = pending;
        if (we) pend_nxt[wa] = 1'b0;
        if (issue_valid) pend_nxt[issue_rd] = 1'b1;
        if (flush) pend_nxt = '0;
        if (ZERO_R0) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_en) regs[wa] <= wd;
            pending <= pend_nxt;
        end
    end

    assign Q0  = regs[0];
    assign Q1  = regs[1];
    assign Q2  = regs[2];
    assign Q3  = regs[3];
    assign Q4  = regs[4];
    assign Q5  = regs[5];
    assign Q6  = regs[6];
    assign Q7  = regs[7];
    assign Q8  = regs[8];
    assign Q9  = regs[9];
    assign Q10 = regs[10];
    assign Q11 = regs[11];
    assign Q12 = regs[12];
    assign Q13 = regs[13];
    assign Q14 = regs[14];
    assign Q15 = regs[15];
    assign Q16 = regs[16];
    assign Q17 = regs[17];
    assign Q18 = regs[18];
    assign Q19 = regs[19];
    assign Q20 = regs[20];
    assign Q21 = regs[21];
    assign Q22 = regs[22];
    assign Q23 = regs[23];
    assign Q24 = regs[24];
    assign Q25 = regs[25];
    assign Q26 = regs[26];
    assign Q27 = regs[27];
    assign Q28 = regs[28];
    assign Q29 = regs[29];
    assign Q30 = regs[30];
    assign Q31 = regs[31];
endmodule

// File: doc/register_bank_sb.md
# register_bank_sb

32-entry × 32-bit architectural register bank with a pending-write scoreboard. It sits directly upstream of the 32:1 read-port multiplexers: it drives all 32 register values in parallel on Q0..Q31, and each read port's mux selects one of them. It accepts one write-back per cycle. It tracks which registers have an in-flight producer so decode can detect RAW hazards.

## Interface
- WIDTH, default 32: data width of each register.
- ZERO_R0, default 1:
  - 1: R0 reads as constant 0, ignores writes and is never marked pending.
  - 0: R0 is an ordinary register.

- clk  input  1: single clock, rising-edge.
- rst_n  input  1: asynchronous, active-low reset.
- we  input  1: write-back enable.
- wa  input  5: write-back register address.
- wd  input  WIDTH: write-back data.
- issue_valid  input  1: an instruction with a destination register is leaving decode this cycle.
- issue_rd  input  5: destination register of the issuing instruction.
- flush  input  1: pipeline flush; clears all pending bits.
- Q0..Q31  output  WIDTH each: current register contents, registered outputs, to the read-port muxes.
- pending  output  32: bit n = 1 means register n has an outstanding write.

## Operation
- Storage: 32 registers of WIDTH bits, plus a 32-bit pending vector.
- Write:
  - On a rising clk edge with we=1, reg[wa] <= wd.
  - With ZERO_R0=1 and wa=0, the write is dropped.
- Read:
  - Qn = reg[n], with no internal bypass.
  - Forwarding of same-cycle write-back is the consumer's job.
- Scoreboard update per edge, applied in this order of precedence:
  1. flush=1: pending <= 0. A coincident issue is ignored.
  2. Otherwise, we=1 clears pending[wa], and issue_valid=1 sets pending[issue_rd].
  3. If issue_rd == wa with both active, the set wins and the bit ends at 1: the new producer supersedes the retiring one.
  4. With ZERO_R0=1, bit 0 is held at 0 regardless of issue/we/flush.
- Flush does not block writes: a we in the flush cycle still updates reg[wa].
- Write-back to a register that is not pending is legal: the data is written and the bit stays 0.
- Duplicate issue to an already-pending register leaves the bit at 1. No counting; in-order retirement is guaranteed upstream.
- No FSM. The behaviour is per-register enable logic plus a set/clear vector.

## Timing
- Reset: asserting rst_n=0 immediately forces all registers to 0, Q0..Q31 = 0 and pending = 0.
  - Reset may be asserted mid-operation; in-flight writes in that cycle are lost.
  - Release is synchronised externally.
- Write latency is 1 cycle. Data presented with we at edge k appears on Q[wa] after edge k. A read in the same cycle as the write returns the old value.
- Pending latency is 1 cycle. The bit is set or cleared after the edge sampling issue_valid/we.
- All outputs are driven from flops, with no combinational path from inputs to outputs.
- One write, one issue and one flush are accepted per cycle, with no stall or back-pressure.

## Test plan
- Reset / R0:
  - Stimulus: assert rst_n=0 mid-run after loading Q5=0xDEADBEEF and pending=0x0000_0020.
  - Required: Q5=0 and pending=0 immediately, without waiting for a clock edge.
  - Stimulus: with ZERO_R0=1, write we=1, wa=0, wd=0xFFFF_FFFF.
  - Required: Q0 stays 0 and pending[0] stays 0.
- Write-back:
  - Stimulus: we=1, wa=7, wd=0x1234_5678 at edge k.
  - Required: Q7=0x1234_5678 after edge k and not before; all other Qn unchanged.
  - Stimulus: sweep all 31 writable addresses with distinct data.
  - Required: every Qn reads back its own value.
- Scoreboard:
  - Stimulus: issue_rd=3 at edge k, then we with wa=3 at edge k+2.
  - Required: pending = 0x0000_0008 after edges k and k+1, and 0 after edge k+2.
- Simultaneous set/clear:
  - Stimulus: pending[9]=1, then in one cycle issue_rd=9 and we with wa=9, wd=0xA5A5_A5A5.
  - Required: Q9=0xA5A5_A5A5 and pending[9]=1.
  - Stimulus: same cycle but issue_rd=4 and wa=9.
  - Required: pending[4]=1 and pending[9]=0.
- Flush:
  - Setup: pending=0x0000_0F00.
  - Stimulus: flush=1 together with issue_rd=2 and we with wa=8, wd=0x55.
  - Required: pending=0 and Q8=0x55.
